// File: rtl/sr_ff_pkg.sv
// Shared constants and helpers for the synchronous SR flip-flop bank.
package sr_ff_pkg;

  localparam logic [1:0] MODE_LOAD   = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b10;

  // Filter counter width; at least one bit so FILTER=0 still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned filter);
    if (filter == 32'd0) return 32'd1;
    return 32'($clog2(filter + 32'd1));
  endfunction

endpackage

// File: rtl/sr_ff_chan.sv
// One SR channel: glitch filters on s/r, priority next-state logic, edge detect.
module sr_ff_chan
  import sr_ff_pkg::*;
#(
  parameter int unsigned FILTER       = 4,
  parameter bit          SET_DOMINANT = 1'b0,
  parameter bit          INIT_BIT     = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_d,
  input  logic       i_en,
  input  logic [1:0] i_mode,
  input  logic       i_s,
  input  logic       i_r,
  output logic       o_q,
  output logic       o_rise,
  output logic       o_fall
);

  localparam int unsigned CW = cnt_width(FILTER);

  logic [CW-1:0] r_s_cnt;
  logic [CW-1:0] r_r_cnt;
  logic          r_q;
  logic          r_q_prev;
  logic          w_s_act;
  logic          w_r_act;
  logic          w_q_nxt;

  // A request acts only once its counter has seen FILTER consecutive high samples.
  assign w_s_act = i_s & (r_s_cnt == CW'(FILTER));
  assign w_r_act = i_r & (r_r_cnt == CW'(FILTER));

  always_comb begin
    w_q_nxt = r_q;
    if (w_s_act && w_r_act) begin
      w_q_nxt = SET_DOMINANT;
    end else if (w_r_act) begin
      w_q_nxt = 1'b0;
    end else if (w_s_act) begin
      w_q_nxt = 1'b1;
    end else if (i_en) begin
      case (i_mode)
        MODE_LOAD:   w_q_nxt = i_d;
        MODE_TOGGLE: w_q_nxt = ~r_q;
        default:     w_q_nxt = r_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s_cnt  <= '0;
      r_r_cnt  <= '0;
      r_q      <= INIT_BIT;
      r_q_prev <= INIT_BIT;
    end else begin
      if (!i_s) begin
        r_s_cnt <= '0;
      end else if (r_s_cnt < CW'(FILTER)) begin
        r_s_cnt <= r_s_cnt + CW'(1);
      end
      if (!i_r) begin
        r_r_cnt <= '0;
      end else if (r_r_cnt < CW'(FILTER)) begin
        r_r_cnt <= r_r_cnt + CW'(1);
      end
      r_q      <= w_q_nxt;
      r_q_prev <= r_q;
    end
  end

  // Pulses decode registers only, so they cannot glitch.
  assign o_q    = r_q;
  assign o_rise = r_q & ~r_q_prev;
  assign o_fall = ~r_q & r_q_prev;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH independent filtered SR flip-flops sharing one data-path mode.
module sr_ff_bank
  import sr_ff_pkg::*;
#(
  parameter int unsigned      WIDTH        = 8,
  parameter int unsigned      FILTER       = 4,
  parameter bit               SET_DOMINANT = 1'b0,
  parameter logic [WIDTH-1:0] INIT         = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    sr_ff_chan #(
      .FILTER       (FILTER),
      .SET_DOMINANT (SET_DOMINANT),
      .INIT_BIT     (INIT[g])
    ) u_chan (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_d    (d[g]),
      .i_en   (en[g]),
      .i_mode (mode),
      .i_s    (s[g]),
      .i_r    (r[g]),
      .o_q    (q[g]),
      .o_rise (rise[g]),
      .o_fall (fall[g])
    );
  end

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed bench: reset-dominant and set-dominant banks driven in lockstep.
module tb_sr_ff_bank;

  logic       clk;
  logic       rst;
  logic [7:0] d, en, s, r;
  logic [1:0] mode;
  logic [7:0] q0, rise0, fall0;
  logic [7:0] q1, rise1, fall1;

  int n_checks = 0;
  int n_errors = 0;

  sr_ff_bank #(.WIDTH(8), .FILTER(4), .SET_DOMINANT(1'b0), .INIT(8'hA5)) dut0 (
    .clk(clk), .rst(rst), .d(d), .en(en), .mode(mode), .s(s), .r(r),
    .q(q0), .rise(rise0), .fall(fall0)
  );

  sr_ff_bank #(.WIDTH(8), .FILTER(4), .SET_DOMINANT(1'b1), .INIT(8'hA5)) dut1 (
    .clk(clk), .rst(rst), .d(d), .en(en), .mode(mode), .s(s), .r(r),
    .q(q1), .rise(rise1), .fall(fall1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check q/rise/fall on both banks against separate expectations.
  task automatic chk_all(input string tag,
                         input logic [7:0] eq0, input logic [7:0] er0, input logic [7:0] ef0,
                         input logic [7:0] eq1, input logic [7:0] er1, input logic [7:0] ef1);
    chk({tag, " q0"}, q0, eq0);
    chk({tag, " rise0"}, rise0, er0);
    chk({tag, " fall0"}, fall0, ef0);
    chk({tag, " q1"}, q1, eq1);
    chk({tag, " rise1"}, rise1, er1);
    chk({tag, " fall1"}, fall1, ef1);
  endtask

  task automatic chk_same(input string tag, input logic [7:0] eq,
                          input logic [7:0] er, input logic [7:0] ef);
    chk_all(tag, eq, er, ef, eq, er, ef);
  endtask

  initial begin
    rst = 1'b1; s = 8'hFF; r = 8'hFF; en = 8'hFF; d = 8'h00; mode = 2'b00;

    // Reset dominates s/r/en
    tick(); chk_same("rst1", 8'hA5, 8'h00, 8'h00);
    tick(); chk_same("rst2", 8'hA5, 8'h00, 8'h00);
    rst = 1'b0; s = 8'h00; r = 8'h00; en = 8'h00;
    tick(); chk_same("post_rst", 8'hA5, 8'h00, 8'h00);

    // Clear everything with a load
    en = 8'hFF; d = 8'h00; mode = 2'b00;
    tick(); chk_same("load_clr", 8'h00, 8'h00, 8'hA5);
    en = 8'h00;
    tick(); chk_same("idle", 8'h00, 8'h00, 8'h00);

    // Filter reject: 4 high samples then low
    s = 8'h01;
    for (int i = 0; i < 4; i++) tick();
    chk_same("rej_4", 8'h00, 8'h00, 8'h00);
    s = 8'h00;
    tick(); chk_same("rej_low", 8'h00, 8'h00, 8'h00);

    // Filter accept: set lands on the 5th edge
    s = 8'h01;
    for (int i = 0; i < 4; i++) tick();
    chk_same("acc_4", 8'h00, 8'h00, 8'h00);
    tick(); chk_same("acc_5", 8'h01, 8'h01, 8'h00);
    s = 8'h00;
    tick(); chk_same("acc_after", 8'h01, 8'h00, 8'h00);

    // Coincident set/reset on channel 1
    s = 8'h02; r = 8'h02;
    for (int i = 0; i < 4; i++) tick();
    chk_all("coin_4", 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
    tick(); chk_all("coin_5", 8'h01, 8'h00, 8'h00, 8'h03, 8'h02, 8'h00);
    s = 8'h00; r = 8'h00;
    tick(); chk_all("coin_rel", 8'h01, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00);

    // Bring the set-dominant bank back via reset request
    r = 8'h02;
    for (int i = 0; i < 5; i++) tick();
    chk_all("rst_ch1", 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02);
    r = 8'h00;
    tick(); chk_same("rst_ch1_rel", 8'h01, 8'h00, 8'h00);

    // Partial load keeps upper nibble
    mode = 2'b00; en = 8'h0F; d = 8'h3C;
    tick(); chk_same("load_lo", 8'h0C, 8'h0C, 8'h01);

    // Toggle channel 0 four times
    mode = 2'b01; en = 8'h01;
    tick(); chk_same("tog1", 8'h0D, 8'h01, 8'h00);
    tick(); chk_same("tog2", 8'h0C, 8'h00, 8'h01);
    tick(); chk_same("tog3", 8'h0D, 8'h01, 8'h00);
    tick(); chk_same("tog4", 8'h0C, 8'h00, 8'h01);
    en = 8'h00;
    tick(); chk_same("tog_stop", 8'h0C, 8'h00, 8'h00);

    // Reserved mode holds
    mode = 2'b11; en = 8'hFF; d = 8'hFF;
    tick(); chk_same("mode_rsv", 8'h0C, 8'h00, 8'h00);
    mode = 2'b10;
    tick(); chk_same("mode_hold", 8'h0C, 8'h00, 8'h00);

    // Set on channel 2 overrides a load of 0
    mode = 2'b00; en = 8'h04; d = 8'h00;
    tick(); chk_same("ld2_zero", 8'h08, 8'h00, 8'h04);
    s = 8'h04;
    for (int i = 0; i < 4; i++) tick();
    chk_same("ovr_4", 8'h08, 8'h00, 8'h00);
    tick(); chk_same("ovr_5", 8'h0C, 8'h04, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_same("ovr_sat", 8'h0C, 8'h00, 8'h00);
    end
    s = 8'h00;
    tick(); chk_same("ovr_rel", 8'h08, 8'h00, 8'h04);
    en = 8'h00;

    // Reset mid-filter restarts the count
    s = 8'h08;
    for (int i = 0; i < 3; i++) tick();
    chk_same("mid_3", 8'h08, 8'h00, 8'h00);
    rst = 1'b1;
    tick(); chk_same("mid_rst", 8'hA5, 8'h00, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_same("mid_cnt", 8'hA5, 8'h00, 8'h00);
    end
    tick(); chk_same("mid_set", 8'hAD, 8'h08, 8'h00);
    s = 8'h00;
    tick(); chk_same("mid_end", 8'hAD, 8'h00, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sr_ff_bank.md
# sr_ff_bank

Parametrised bank of WIDTH set/reset flip-flops. Each channel has a glitch-filtered synchronous set and reset, a per-channel load/toggle/hold data path, and registered-edge rise/fall pulse outputs. It is the next-generation replacement for single-bit SR flip-flops in the Tang Nano designs, such as button and latch status flags. All set/reset action is synchronous to clk, so the block is timing-clean and free of asynchronous paths.

## Interface
Parameters:
- WIDTH, 8: number of independent channels (≥1).
- FILTER, 4: number of consecutive clk edges s/r must be sampled high before acting (0 = no filter; max 255).
- SET_DOMINANT, 0: when qualified s and r coincide, 1 = set wins, 0 = reset wins.
- INIT, {WIDTH{1'b0}}: value of q after rst.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high block reset.
- d  in  WIDTH  per-channel load data.
- en  in  WIDTH  per-channel data-path enable.
- mode  in  2  shared data-path mode: 00 LOAD, 01 TOGGLE, 10 HOLD, 11 reserved (behaves as HOLD).
- s  in  WIDTH  per-channel set request, level, unfiltered.
- r  in  WIDTH  per-channel reset request, level, unfiltered.
- q  out  WIDTH  registered channel state.
- rise  out  WIDTH  one-cycle pulse when q[i] went 0→1 on the previous edge.
- fall  out  WIDTH  one-cycle pulse when q[i] went 1→0 on the previous edge.

## Operation
- Filter, per channel, separately for s and r:
  - Counter cnt, width $clog2(FILTER+1).
  - Each edge: if input is 0, cnt←0; else if cnt<FILTER, cnt←cnt+1 (saturates).
  - Qualified level: act = input & (cnt==FILTER). FILTER=0 gives act = input; counters are unused and optimised away.
- Next-state priority for q[i], highest first:
  1. rst: q←INIT[i].
  2. s_act & r_act: q←SET_DOMINANT.
  3. r_act: q←0.
  4. s_act: q←1.
  5. en[i] & mode=LOAD: q←d[i].
  6. en[i] & mode=TOGGLE: q←~q[i].
  7. Otherwise: hold.
- Set/reset are levels. While act is held, q is pinned, and en/mode/d are ignored for that channel.
- Edge detect: q_prev←q each edge (rst: q_prev←INIT). rise = q & ~q_prev; fall = ~q & q_prev. Both are combinational from registers only, so they are glitch-free.
- Channels are fully independent; only mode is shared.

## Timing
- Reset values:
  - q = INIT; rise = fall = 0.
  - All filter counters = 0; q_prev = INIT.
- LOAD/TOGGLE: q updates on the edge that samples en; latency 1 cycle. rise/fall appear the following cycle, for exactly 1 cycle.
- s/r: q changes on the (FILTER+1)-th consecutive edge sampling the input high; latency FILTER+1 cycles.
- A low sample of s or r at any point restarts its count. A pulse shorter than FILTER+1 edges has no effect.
- Continuous TOGGLE with en=1 toggles q every cycle, so rise and fall alternate each cycle.
- rst mid-filter clears the counters. After rst deasserts, s/r require a full FILTER+1 fresh edges.
- rst asserted together with s/r/en: rst wins. The first cycle after rst shows no rise/fall pulse.
- Counter saturation: holding s for any length never wraps cnt. The set stays in force and no extra rise pulse is produced.

## Structure
- Package sr_ff_pkg:
  - Mode constants MODE_LOAD=2'b00, MODE_TOGGLE=2'b01, MODE_HOLD=2'b10.
  - A function computing the counter width from FILTER.
- Sub-module sr_ff_chan: one channel holding both filters, the q/q_prev registers and the priority logic, with parameters FILTER, SET_DOMINANT and INIT_BIT.
- sr_ff_bank instantiates WIDTH channels in a generate loop.

## Test plan
- Reset: WIDTH=8, INIT=8'hA5. Assert rst for 2 cycles with s=r=en=8'hFF. Required: q=8'hA5, rise=fall=0 during reset and in the first cycle after.
- Filter reject/accept: FILTER=4, s[0] high for 4 edges then low. Required: q[0] unchanged. Then s[0] high for 5 edges. Required: q[0]=1 after the 5th edge, rise[0]=1 for exactly the next cycle.
- Coincident set/reset: s[1]=r[1]=1 held for 5 edges. Required: q[1]=0 with SET_DOMINANT=0, and q[1]=1 with SET_DOMINANT=1.
- Load/toggle: mode=LOAD, en=8'h0F, d=8'h3C gives q[3:0]=4'hC with q[7:4] held. Then mode=TOGGLE, en=8'h01 for 4 cycles. Required: q[0] sequence 1,0,1,0 and rise[0]/fall[0] alternating one cycle later.
- Set overrides data path: s[2] qualified while en[2]=1, mode=LOAD, d[2]=0. Required: q[2] stays 1 for as long as s[2] is held.
- Reset mid-filter: s[3] high for 3 edges, rst for 1 cycle, then s[3] held. Required: q[3] sets only on the 5th edge after rst deasserts.
